im_fetch_arbiter: RTL and testbench

Arbiter and sequencer for the shared single-port instruction memory. It grants access to two requesters: the CPU fetch port, driven from the PC, and the program-loader port, which writes or reads back code words. It also holds the CPU fetch port off until loading is complete. It sits between the PC/fetch stage, the boot loader and a synchronous instruction RAM.

---
 rtl/im_fetch_arbiter.sv | 127 ++++++++++++
 tb/tb_im_fetch_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/im_fetch_arbiter.sv
// im_fetch_arbiter: shares one synchronous single-port instruction RAM between
// the CPU fetch port and the program-loader port. It also keeps fetch disabled
// until the boot image has been loaded.
module im_fetch_arbiter #(
    parameter int         ADDR_W    = 10,
    parameter logic [3:0] BASE_HI   = 4'h3,
    parameter bit         BOOT_HOLD = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    // CPU fetch port
    input  logic              f_req,
    input  logic [31:0]       f_addr,
    output logic              f_gnt,
    output logic              f_rvalid,
    output logic [31:0]       f_rdata,
    output logic              f_fault,
    // Program-loader port
    input  logic              l_req,
    input  logic              l_we,
    input  logic [31:0]       l_addr,
    input  logic [31:0]       l_wdata,
    input  logic              l_boot_done,
    output logic              l_gnt,
    output logic              l_rvalid,
    output logic [31:0]       l_rdata,
    output logic              l_fault,
    output logic              cpu_run,
    // Instruction RAM
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic {
        PORT_FETCH = 1'b0,
        PORT_LOAD  = 1'b1
    } port_e;

    port_e       rr_q, rr_d;
    logic        cpu_run_q, cpu_run_d;
    logic        resp_valid_q, resp_valid_d;
    port_e       resp_owner_q, resp_owner_d;
    logic        resp_fault_q, resp_fault_d;
    logic        resp_write_q, resp_write_d;

    logic        f_elig, l_elig;
    logic        f_gnt_c, l_gnt_c, any_gnt;
    logic [31:0] sel_addr;
    logic        sel_legal;
    logic [31:0] resp_rdata;

    // Only the word-index, region and alignment bits take part in decoding.
    logic        unused_addr_bits;
    assign unused_addr_bits = ^{f_addr, l_addr};

    // An access is legal only inside the code region and on a word boundary.
    function automatic logic is_legal(input logic [31:0] a);
        return (a[15:12] == BASE_HI) && (a[1:0] == 2'b00);
    endfunction

    // Grant selection, RAM drive and next-state for rr, boot and response regs.
    always_comb begin
        f_elig       = f_req && cpu_run_q;
        l_elig       = l_req;
        f_gnt_c      = reset_n && f_elig && (!l_elig || (rr_q == PORT_FETCH));
        l_gnt_c      = reset_n && l_elig && (!f_elig || (rr_q == PORT_LOAD));
        any_gnt      = f_gnt_c || l_gnt_c;
        sel_addr     = l_gnt_c ? l_addr : f_addr;
        sel_legal    = is_legal(sel_addr);

        mem_en       = any_gnt && sel_legal;
        mem_we       = any_gnt && sel_legal && l_gnt_c && l_we;
        mem_addr     = sel_addr[ADDR_W+1:2];
        mem_wdata    = l_wdata;

        rr_d         = rr_q;
        if (f_gnt_c) begin
            rr_d = PORT_LOAD;
        end else if (l_gnt_c) begin
            rr_d = PORT_FETCH;
        end

        cpu_run_d    = cpu_run_q || l_boot_done;

        resp_valid_d = any_gnt;
        resp_owner_d = l_gnt_c ? PORT_LOAD : PORT_FETCH;
        resp_fault_d = any_gnt && !sel_legal;
        resp_write_d = l_gnt_c && l_we;
    end

    // State registers; a pending response is discarded by reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_q         <= PORT_FETCH;
            cpu_run_q    <= ~BOOT_HOLD;
            resp_valid_q <= 1'b0;
            resp_owner_q <= PORT_FETCH;
            resp_fault_q <= 1'b0;
            resp_write_q <= 1'b0;
        end else begin
            rr_q         <= rr_d;
            cpu_run_q    <= cpu_run_d;
            resp_valid_q <= resp_valid_d;
            resp_owner_q <= resp_owner_d;
            resp_fault_q <= resp_fault_d;
            resp_write_q <= resp_write_d;
        end
    end

    // Response steering: data only for legal reads, everything zero when idle.
    always_comb begin
        f_gnt      = f_gnt_c;
        l_gnt      = l_gnt_c;
        cpu_run    = cpu_run_q;
        f_rvalid   = resp_valid_q && (resp_owner_q == PORT_FETCH);
        l_rvalid   = resp_valid_q && (resp_owner_q == PORT_LOAD);
        resp_rdata = (resp_valid_q && !resp_fault_q && !resp_write_q) ? mem_rdata : 32'h0;
        f_rdata    = f_rvalid ? resp_rdata : 32'h0;
        l_rdata    = l_rvalid ? resp_rdata : 32'h0;
        f_fault    = f_rvalid && resp_fault_q;
        l_fault    = l_rvalid && resp_fault_q;
    end

endmodule

// File: tb/tb_im_fetch_arbiter.sv
// Testbench for im_fetch_arbiter: a table of per-cycle vectors with expected
// grants and RAM strobes, plus a queue of expected responses checked one cycle
// later. A behavioural synchronous RAM is attached to the memory port.
module tb_im_fetch_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        f_req, l_req, l_we, l_boot_done;
    logic [31:0] f_addr, l_addr, l_wdata;
    logic        f_gnt, f_rvalid, f_fault, l_gnt, l_rvalid, l_fault, cpu_run;
    logic [31:0] f_rdata, l_rdata;
    logic        mem_en, mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    logic [31:0] ram [1024];
    logic [31:0] shadow [1024];
    logic [31:0] load_data [8];

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        string       name;
        logic        f_req;
        logic [31:0] f_addr;
        logic        l_req;
        logic        l_we;
        logic [31:0] l_addr;
        logic [31:0] l_wdata;
        logic        boot;
        logic        e_fgnt;
        logic        e_lgnt;
        logic        e_men;
        logic        e_mwe;
        logic [9:0]  e_maddr;
        logic        e_run;
    } vec_t;

    typedef struct {
        logic        valid;
        logic        owner;
        logic        fault;
        logic [31:0] rdata;
    } resp_t;

    vec_t  vecs [$];
    resp_t resp_q [$];

    im_fetch_arbiter dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .f_req       (f_req),
        .f_addr      (f_addr),
        .f_gnt       (f_gnt),
        .f_rvalid    (f_rvalid),
        .f_rdata     (f_rdata),
        .f_fault     (f_fault),
        .l_req       (l_req),
        .l_we        (l_we),
        .l_addr      (l_addr),
        .l_wdata     (l_wdata),
        .l_boot_done (l_boot_done),
        .l_gnt       (l_gnt),
        .l_rvalid    (l_rvalid),
        .l_rdata     (l_rdata),
        .l_fault     (l_fault),
        .cpu_run     (cpu_run),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Synchronous single-port RAM: read data appears the cycle after mem_en.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata <= ram[mem_addr];
        end
    end

    function automatic logic tb_legal(input logic [31:0] a);
        return (a[15:12] == 4'h3) && (a[1:0] == 2'b00);
    endfunction

    function automatic vec_t mk(input string n, input logic fr, input logic [31:0] fa,
                                input logic lr, input logic lw, input logic [31:0] la,
                                input logic [31:0] ld, input logic bt, input logic gf,
                                input logic gl, input logic me, input logic mw,
                                input logic [9:0] ma, input logic run);
        vec_t v;
        v.name = n;  v.f_req = fr;  v.f_addr = fa;  v.l_req = lr;  v.l_we = lw;
        v.l_addr = la;  v.l_wdata = ld;  v.boot = bt;  v.e_fgnt = gf;  v.e_lgnt = gl;
        v.e_men = me;  v.e_mwe = mw;  v.e_maddr = ma;  v.e_run = run;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Compare the response ports against the record queued one cycle earlier.
    task automatic checkResponse(input string name);
        resp_t e;
        if (resp_q.size() > 0) e = resp_q.pop_front();
        else e = '{valid: 1'b0, owner: 1'b0, fault: 1'b0, rdata: 32'h0};
        checkOutput({name, ".f_rvalid"}, f_rvalid, e.valid && !e.owner);
        checkOutput({name, ".l_rvalid"}, l_rvalid, e.valid && e.owner);
        checkOutput({name, ".f_rdata"}, f_rdata, (e.valid && !e.owner) ? e.rdata : 32'h0);
        checkOutput({name, ".l_rdata"}, l_rdata, (e.valid && e.owner) ? e.rdata : 32'h0);
        checkOutput({name, ".f_fault"}, f_fault, e.valid && !e.owner && e.fault);
        checkOutput({name, ".l_fault"}, l_fault, e.valid && e.owner && e.fault);
    endtask

    // Drive one cycle of stimulus, check combinational outputs mid-cycle and
    // queue the response the bench expects for the following cycle.
    task automatic applyStimulus(input vec_t v);
        resp_t       r;
        logic [31:0] a;
        @(posedge clk);
        #1;
        f_req = v.f_req;  f_addr = v.f_addr;  l_req = v.l_req;  l_we = v.l_we;
        l_addr = v.l_addr;  l_wdata = v.l_wdata;  l_boot_done = v.boot;
        @(negedge clk);
        checkOutput({v.name, ".f_gnt"}, f_gnt, v.e_fgnt);
        checkOutput({v.name, ".l_gnt"}, l_gnt, v.e_lgnt);
        checkOutput({v.name, ".mem_en"}, mem_en, v.e_men);
        checkOutput({v.name, ".mem_we"}, mem_we, v.e_mwe);
        if (v.e_men) checkOutput({v.name, ".mem_addr"}, mem_addr, v.e_maddr);
        checkOutput({v.name, ".cpu_run"}, cpu_run, v.e_run);
        checkResponse(v.name);
        r = '{valid: 1'b0, owner: 1'b0, fault: 1'b0, rdata: 32'h0};
        if (v.e_fgnt || v.e_lgnt) begin
            a       = v.e_lgnt ? v.l_addr : v.f_addr;
            r.valid = 1'b1;
            r.owner = v.e_lgnt;
            r.fault = !tb_legal(a);
            if (tb_legal(a)) begin
                if (v.e_lgnt && v.l_we) shadow[a[11:2]] = v.l_wdata;
                else                    r.rdata = shadow[a[11:2]];
            end
        end
        resp_q.push_back(r);
    endtask

    initial begin
        reset_n = 1'b0;
        f_req = 1'b1;  f_addr = 32'h3000;  l_req = 1'b1;  l_we = 1'b1;
        l_addr = 32'h3000;  l_wdata = 32'hDEAD_BEEF;  l_boot_done = 1'b0;
        for (int i = 0; i < 8; i++) load_data[i] = 32'h1000_0000 + i * 32'h11;
        load_data[1] = 32'h2402_000A;

        // Reset values while both ports request.
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset.f_gnt", f_gnt, 0);
        checkOutput("reset.l_gnt", l_gnt, 0);
        checkOutput("reset.mem_en", mem_en, 0);
        checkOutput("reset.mem_we", mem_we, 0);
        checkOutput("reset.cpu_run", cpu_run, 0);
        checkResponse("reset");
        f_req = 1'b0;  l_req = 1'b0;
        reset_n = 1'b1;

        // Load the image while fetch is blocked by the boot hold.
        for (int i = 0; i < 8; i++)
            vecs.push_back(mk("load_wr", 1, 32'h3000, 1, 1, 32'h3000 + i * 4, load_data[i],
                              0, 0, 1, 1, 1, i[9:0], 0));
        vecs.push_back(mk("boot_pulse", 1, 32'h3000, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("first_fetch", 1, 32'h3000, 0, 0, 0, 0, 0, 1, 0, 1, 0, 10'd0, 1));
        vecs.push_back(mk("fetch_3004", 1, 32'h3004, 0, 0, 0, 0, 0, 1, 0, 1, 0, 10'd1, 1));
        vecs.push_back(mk("fault_region", 1, 32'h4000, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1));
        vecs.push_back(mk("fault_align", 1, 32'h3002, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1));
        vecs.push_back(mk("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk("load_rd", 0, 0, 1, 0, 32'h3004, 0, 0, 0, 1, 1, 0, 10'd1, 1));
        vecs.push_back(mk("load_wr_bad", 0, 0, 1, 1, 32'h5008, 32'h1234, 0, 0, 1, 0, 0, 0, 1));
        vecs.push_back(mk("boot_again", 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1));
        // Contention: both held, grants alternate starting with fetch.
        for (int i = 0; i < 6; i++)
            vecs.push_back(mk("contend", 1, 32'h3008, 1, 0, 32'h300C, 0, 0,
                              (i % 2) == 0, (i % 2) == 1, 1, 0,
                              ((i % 2) == 0) ? 10'd2 : 10'd3, 1));
        // Streaming fetch of words 0..7.
        for (int i = 0; i < 8; i++)
            vecs.push_back(mk("stream", 1, 32'h3000 + i * 4, 0, 0, 0, 0, 0, 1, 0, 1, 0,
                              i[9:0], 1));
        vecs.push_back(mk("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));

        foreach (vecs[i]) applyStimulus(vecs[i]);

        // Reset arrives while a fetch response is pending.
        applyStimulus(mk("pre_reset", 1, 32'h3010, 0, 0, 0, 0, 0, 1, 0, 1, 0, 10'd4, 1));
        @(posedge clk);
        #1 reset_n = 1'b0;
        @(negedge clk);
        checkOutput("midreset.f_rvalid", f_rvalid, 0);
        checkOutput("midreset.f_rdata", f_rdata, 0);
        checkOutput("midreset.f_gnt", f_gnt, 0);
        checkOutput("midreset.mem_en", mem_en, 0);
        checkOutput("midreset.l_rvalid", l_rvalid, 0);
        checkOutput("midreset.cpu_run", cpu_run, 0);
        resp_q.delete();
        reset_n = 1'b1;
        applyStimulus(mk("post_reset", 1, 32'h3000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        applyStimulus(mk("post_reset2", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
